// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the CPU datapath and alu_seq.
//   start_i / op_i / x_i / y_i : request, driven by the master (datapath)
//   r_o / fz_o fc_o fn_o fv_o : registered result and flags, driven by the ALU
//   busy_o / done_o           : handshake status, driven by the ALU
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start_i;
  logic [3:0]       op_i;
  logic [WIDTH-1:0] x_i;
  logic [WIDTH-1:0] y_i;
  logic [WIDTH-1:0] r_o;
  logic             fz_o;
  logic             fc_o;
  logic             fn_o;
  logic             fv_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, op_i, x_i, y_i,
    input  r_o, fz_o, fc_o, fn_o, fv_o, busy_o, done_o
  );

  modport slave (
    input  start_i, op_i, x_i, y_i,
    output r_o, fz_o, fc_o, fn_o, fv_o, busy_o, done_o
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with persistent Z/C/N/V flags and a start/busy/done
// handshake. Single-cycle ops complete on the accepting edge; MUL is an
// iterative shift-add taking WIDTH further edges.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : alu_seq_if slave (request operands, result, flags, busy/done)
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  alu_seq_if.slave   bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam int M = WIDTH - 1;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
    OP_ADC = 4'd8, OP_SBC = 4'd9, OP_MUL = 4'd10, OP_CMP = 4'd11
  } op_e;

  typedef enum logic [0:0] {IDLE, MUL_RUN} state_e;

  state_e             r_state;
  logic [WIDTH-1:0]   r_res;
  logic               r_fz, r_fc, r_fn, r_fv;
  logic               r_busy, r_done;
  logic [2*WIDTH-1:0] r_mx;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]   r_my;   // multiplier, shifted right each step
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;

  logic               w_cin, w_bin;
  logic [WIDTH:0]     w_add, w_sub;
  logic               w_add_v, w_sub_v;
  logic [WIDTH-1:0]   w_res;
  logic               w_c, w_v, w_wr_r, w_wr_f;
  logic               w_is_mul;
  logic [2*WIDTH-1:0] w_acc_next;

  // Carry-in / borrow-in come from the flag as it stands at the accepting edge.
  assign w_cin   = (bus.op_i == OP_ADC) & r_fc;
  assign w_bin   = (bus.op_i == OP_SBC) & r_fc;
  assign w_add   = {1'b0, bus.y_i} + {1'b0, bus.x_i} + {{WIDTH{1'b0}}, w_cin};
  assign w_sub   = {1'b0, bus.y_i} - {1'b0, bus.x_i} - {{WIDTH{1'b0}}, w_bin};
  assign w_add_v = (bus.y_i[M] == bus.x_i[M]) && (w_add[M] != bus.y_i[M]);
  assign w_sub_v = (bus.y_i[M] != bus.x_i[M]) && (w_sub[M] != bus.y_i[M]);
  assign w_is_mul = MUL_EN && (bus.op_i == OP_MUL);
  assign w_acc_next = r_acc + (r_my[0] ? r_mx : '0);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_res  = r_res;
    w_c    = 1'b0;
    w_v    = 1'b0;
    w_wr_r = 1'b1;
    w_wr_f = 1'b1;
    case (bus.op_i)
      OP_ADD, OP_ADC: begin w_res = w_add[M:0]; w_c = w_add[WIDTH]; w_v = w_add_v; end
      OP_SUB, OP_SBC: begin w_res = w_sub[M:0]; w_c = w_sub[WIDTH]; w_v = w_sub_v; end
      OP_CMP: begin
        // Flags follow the difference; the result register is left alone.
        w_res = w_sub[M:0]; w_c = w_sub[WIDTH]; w_v = w_sub_v; w_wr_r = 1'b0;
      end
      OP_AND: w_res = bus.y_i & bus.x_i;
      OP_OR:  w_res = bus.y_i | bus.x_i;
      OP_XOR: w_res = bus.y_i ^ bus.x_i;
      OP_NOT: w_res = ~bus.x_i;
      OP_SHL: begin w_res = {bus.x_i[M-1:0], 1'b0}; w_c = bus.x_i[M]; end
      OP_SHR: begin w_res = {1'b0, bus.x_i[M:1]};   w_c = bus.x_i[0]; end
      // Codes 12-15, and code 10 with MUL_EN=0, keep result and flags.
      default: begin w_wr_r = 1'b0; w_wr_f = 1'b0; end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_res   <= '0;
      r_fz    <= 1'b0;
      r_fc    <= 1'b0;
      r_fn    <= 1'b0;
      r_fv    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mx    <= '0;
      r_my    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge value of the others regardless of statement order.
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            if (w_is_mul) begin
              r_mx    <= {{WIDTH{1'b0}}, bus.x_i};
              r_my    <= bus.y_i;
              r_acc   <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= MUL_RUN;
            end else begin
              r_done <= 1'b1;
              if (w_wr_r) r_res <= w_res;
              if (w_wr_f) begin
                r_fz <= (w_res == '0);
                r_fc <= w_c;
                r_fn <= w_res[M];
                r_fv <= w_v;
              end
            end
          end
        end
        MUL_RUN: begin
          r_acc <= w_acc_next;
          r_mx  <= r_mx << 1;
          r_my  <= r_my >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            r_res   <= w_acc_next[M:0];
            r_fz    <= (w_acc_next[M:0] == '0);
            r_fc    <= |w_acc_next[2*WIDTH-1:WIDTH];
            r_fn    <= w_acc_next[M];
            r_fv    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.r_o    = r_res;
  assign bus.fz_o   = r_fz;
  assign bus.fc_o   = r_fc;
  assign bus.fn_o   = r_fn;
  assign bus.fv_o   = r_fv;
  assign bus.busy_o = r_busy;
  assign bus.done_o = r_done;
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8)) bus ();
  alu_seq_if #(.WIDTH(8)) bus0 ();

  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) u_dut  (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) u_dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0));

  typedef struct {
    logic [3:0] op;
    logic [7:0] y;
    logic [7:0] x;
    logic [7:0] r;
    logic [3:0] f;   // {Z,C,N,V}
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] flags();
    return {bus.fz_o, bus.fc_o, bus.fn_o, bus.fv_o};
  endfunction

  task automatic drive(input logic s, input logic [3:0] op, input logic [7:0] y, input logic [7:0] x);
    bus.start_i = s; bus.op_i = op; bus.y_i = y; bus.x_i = x;
  endtask

  initial begin
    vecs[0]  = '{4'd0,  8'h01, 8'hFF, 8'h00, 4'b1100};
    vecs[1]  = '{4'd0,  8'h01, 8'h01, 8'h02, 4'b0000};
    vecs[2]  = '{4'd1,  8'h01, 8'h04, 8'hFD, 4'b0110};
    vecs[3]  = '{4'd9,  8'h00, 8'h00, 8'hFF, 4'b0110};
    vecs[4]  = '{4'd1,  8'h05, 8'h02, 8'h03, 4'b0000};
    vecs[5]  = '{4'd11, 8'h03, 8'h03, 8'h03, 4'b1000};
    vecs[6]  = '{4'd13, 8'h55, 8'h22, 8'h03, 4'b1000};
    vecs[7]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 4'b0011};
    vecs[8]  = '{4'd1,  8'h80, 8'h01, 8'h7F, 4'b0001};
    vecs[9]  = '{4'd2,  8'hF0, 8'h3C, 8'h30, 4'b0000};
    vecs[10] = '{4'd3,  8'hF0, 8'h0C, 8'hFC, 4'b0010};
    vecs[11] = '{4'd4,  8'hAA, 8'hAA, 8'h00, 4'b1000};
    vecs[12] = '{4'd5,  8'h00, 8'h0F, 8'hF0, 4'b0010};
    vecs[13] = '{4'd6,  8'h00, 8'h81, 8'h02, 4'b0100};
    vecs[14] = '{4'd7,  8'h00, 8'h81, 8'h40, 4'b0100};
    vecs[15] = '{4'd0,  8'hFF, 8'h01, 8'h00, 4'b1100};
    vecs[16] = '{4'd8,  8'h00, 8'h00, 8'h01, 4'b0000};
    vecs[17] = '{4'd1,  8'h00, 8'h01, 8'hFF, 4'b0110};
    vecs[18] = '{4'd12, 8'h12, 8'h34, 8'hFF, 4'b0110};
    vecs[19] = '{4'd7,  8'h00, 8'h02, 8'h01, 4'b0000};

    bus0.start_i = 1'b0; bus0.op_i = 4'd0; bus0.y_i = 8'h00; bus0.x_i = 8'h00;

    // Reset held with a pending request: everything stays cleared.
    drive(1'b1, 4'd0, 8'h01, 8'h01);
    tick(); tick();
    check("rst_r",    32'(bus.r_o), 32'h0);
    check("rst_flag", 32'(flags()), 32'h0);
    check("rst_busy", 32'(bus.busy_o), 32'h0);
    check("rst_done", 32'(bus.done_o), 32'h0);
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    tick(); tick(); tick();
    check("idle_done", 32'(bus.done_o), 32'h0);
    check("idle_r",    32'(bus.r_o), 32'h0);

    // Back-to-back single-cycle vectors.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].y, vecs[i].x);
      tick();
      check($sformatf("v%0d_r", i),    32'(bus.r_o), 32'(vecs[i].r));
      check($sformatf("v%0d_flag", i), 32'(flags()), 32'(vecs[i].f));
      check($sformatf("v%0d_done", i), 32'(bus.done_o), 32'h1);
      check($sformatf("v%0d_busy", i), 32'(bus.busy_o), 32'h0);
    end
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    tick();
    check("done_drop", 32'(bus.done_o), 32'h0);

    // MUL 13*20 = 0x104; a start during busy must be ignored.
    drive(1'b1, 4'd10, 8'd13, 8'd20);
    tick();
    check("mul_busy0", 32'(bus.busy_o), 32'h1);
    check("mul_done0", 32'(bus.done_o), 32'h0);
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    for (int c = 1; c < 8; c++) begin
      if (c == 2) drive(1'b1, 4'd0, 8'h01, 8'h01);
      else drive(1'b0, 4'd0, 8'h00, 8'h00);
      tick();
      check($sformatf("mul_busy%0d", c), 32'(bus.busy_o), 32'h1);
      check($sformatf("mul_done%0d", c), 32'(bus.done_o), 32'h0);
    end
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    tick();
    check("mul_end_busy", 32'(bus.busy_o), 32'h0);
    check("mul_end_done", 32'(bus.done_o), 32'h1);
    check("mul_r",        32'(bus.r_o), 32'h04);
    check("mul_flag",     32'(flags()), 32'b0100);
    tick();
    check("mul_done_drop", 32'(bus.done_o), 32'h0);
    check("mul_no_extra",  32'(bus.r_o), 32'h04);

    // MUL_EN=0: MUL opcode behaves as reserved.
    bus0.start_i = 1'b1; bus0.op_i = 4'd0; bus0.y_i = 8'd2; bus0.x_i = 8'd3;
    tick();
    check("m0_add_r", 32'(bus0.r_o), 32'h05);
    bus0.op_i = 4'd10; bus0.y_i = 8'd13; bus0.x_i = 8'd20;
    tick();
    bus0.start_i = 1'b0;
    check("m0_mul_done", 32'(bus0.done_o), 32'h1);
    check("m0_mul_busy", 32'(bus0.busy_o), 32'h0);
    check("m0_mul_r",    32'(bus0.r_o), 32'h05);
    check("m0_mul_flag", 32'({bus0.fz_o, bus0.fc_o, bus0.fn_o, bus0.fv_o}), 32'h0);
    tick();
    check("m0_done_drop", 32'(bus0.done_o), 32'h0);

    // Reset in the 4th cycle of a MUL aborts it without done.
    drive(1'b1, 4'd10, 8'd13, 8'd20);
    tick();
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    tick(); tick(); tick();
    check("abort_busy_pre", 32'(bus.busy_o), 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy_o), 32'h0);
    check("abort_r",    32'(bus.r_o), 32'h0);
    check("abort_done", 32'(bus.done_o), 32'h0);
    check("abort_flag", 32'(flags()), 32'h0);
    for (int c = 0; c < 8; c++) tick();
    check("abort_nodone", 32'(bus.done_o), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    drive(1'b1, 4'd0, 8'd2, 8'd2);
    tick();
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    check("post_add_r",    32'(bus.r_o), 32'h04);
    check("post_add_done", 32'(bus.done_o), 32'h1);
    check("post_add_flag", 32'(flags()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the 8-bit combinational ALU in the datapath.
- Operand width is generic. Results and a four-bit flag register (Z, C, N, V) are held between operations.
- Adds carry-chained ops (ADC/SBC), compare, shifts and an iterative shift-add multiplier, all behind a start/busy/done handshake.
- Sits between the register file and the accumulator write-back in the simulated CPU.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2).
MUL_EN, 1, 1 = MUL implemented; 0 = MUL opcode behaves as reserved.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  request; accepted when start_i=1 and busy_o=0
op_i  input  4  operation code, sampled at accept
x_i  input  WIDTH  operand X, sampled at accept
y_i  input  WIDTH  operand Y, sampled at accept
r_o  output  WIDTH  registered result
fz_o  output  1  zero flag
fc_o  output  1  carry/borrow flag
fn_o  output  1  negative flag (MSB of result)
fv_o  output  1  signed overflow flag
busy_o  output  1  high while a multi-cycle op is running
done_o  output  1  one-cycle pulse when r_o/flags have been updated

Behaviour:
- Reset (rst_ni=0, immediate, any state):
  - r_o=0, all flags=0, busy_o=0, done_o=0, FSM=IDLE.
  - An in-flight MUL is aborted with no done_o.
- FSM states: IDLE, MUL_RUN.
- IDLE, accept of a single-cycle op:
  - On the accepting edge, r_o and flags update and done_o=1 for the following cycle.
  - Latency is 1 edge. Back-to-back starts are allowed every cycle.
- IDLE, accept of MUL (MUL_EN=1):
  - Operands are latched, busy_o=1, FSM goes to MUL_RUN.
  - One partial-product step per edge for WIDTH edges.
  - On the WIDTH-th edge after accept: r_o/flags update, busy_o=0, done_o=1 for one cycle, FSM returns to IDLE.
- start_i while busy_o=1 is ignored; no queuing.
- done_o is deasserted in every cycle not immediately following an update.
- Opcodes (r = WIDTH-bit result; arithmetic is modulo 2^WIDTH):
  - 0 ADD: r=y+x. C=carry out. V=signed overflow.
  - 1 SUB: r=y-x. C=borrow (1 when y<x unsigned). V=signed overflow of y-x.
  - 2 AND, 3 OR, 4 XOR: bitwise. C=0, V=0.
  - 5 NOT: r=~x. C=0, V=0.
  - 6 SHL: r=x<<1. C=x[WIDTH-1]. V=0.
  - 7 SHR: r=x>>1 (logical). C=x[0]. V=0.
  - 8 ADC: r=y+x+C_prev. Carry and overflow as ADD.
  - 9 SBC: r=y-x-C_prev. Borrow and overflow as SUB.
  - 10 MUL: r=low WIDTH bits of y*x (unsigned). C=1 if upper WIDTH bits are nonzero. V=0.
  - 11 CMP: flags as SUB; r_o unchanged.
  - 12–15 reserved, and 10 when MUL_EN=0: r_o and flags unchanged, done_o still pulses after 1 edge.
- For every op that writes flags: Z=(computed result==0) and N=computed result MSB. This includes CMP, even though r_o is not written.
- C_prev is the fc_o value at the accepting edge.

Test Plan:
- Reset: hold rst_ni=0 with start_i=1 -> r_o=0, fz/fc/fn/fv=0, busy_o=0, done_o=0; release -> remains idle until a start.
- ADD y=1, x=255 (WIDTH=8) -> after 1 edge r_o=0, Z=1, C=1, N=0, V=0, done_o high exactly one cycle. Then ADD y=1, x=1 next cycle -> r_o=2, Z=0, C=0.
- SUB y=1, x=4 -> r_o=0xFD, C=1, N=1, Z=0. Then SBC y=0, x=0 -> r_o=0xFF, C=1. Then SUB y=5, x=2 -> r_o=3, C=0.
- CMP y=3, x=3 after r_o=3 -> Z=1, C=0, r_o stays 3; opcode 13 -> r_o/flags unchanged, done_o pulses.
- MUL y=13, x=20 -> busy_o high 8 cycles, done_o on 8th edge, r_o=0x04, C=1. Second start_i during busy is ignored (no extra done_o). With MUL_EN=0, the same stimulus -> r_o unchanged, done after 1 edge.
- Drop rst_ni on the 4th cycle of a MUL -> busy_o=0, r_o=0 immediately, no done_o. After release, ADD y=2, x=2 -> r_o=4.
